// File: rtl/hazard_controller.sv
// hazard_controller: fetch/frontend/backend stall generation from I-cache
// state, ROB occupancy, a register RAW scoreboard and a multi-cycle redirect
// flush. Tracks ROB occupancy and per-register pending writes internally.
// Optional build macro: HAZARD_PERF_EN adds saturating performance counters
// (perf_fetch_stall, perf_raw_stall, perf_flush).
module hazard_controller #(
  parameter int ROB_DEPTH    = 16,
  parameter int ROB_HEADROOM = 1,
  parameter int NUM_REGS     = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           icache_busy,
  input  logic                           instr_valid,
  input  logic                           redirect,
  input  logic                           dispatch_valid,
  input  logic                           dispatch_rd_we,
  input  logic [$clog2(NUM_REGS)-1:0]    dispatch_rd,
  input  logic                           rs1_used,
  input  logic                           rs2_used,
  input  logic [$clog2(NUM_REGS)-1:0]    rs1,
  input  logic [$clog2(NUM_REGS)-1:0]    rs2,
  input  logic                           wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]    wb_rd,
  input  logic                           retire_valid,
  input  logic                           backend_busy,
  output logic                           fetch_stall,
  output logic                           frontend_stall,
  output logic                           backend_stall,
  output logic                           flush,
  output logic                           rob_full,
  output logic [$clog2(ROB_DEPTH+1)-1:0] rob_count
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]               perf_fetch_stall,
  output logic [CNT_W-1:0]               perf_raw_stall,
  output logic [CNT_W-1:0]               perf_flush
`endif
);

  localparam int RW       = $clog2(NUM_REGS);
  localparam int RC_W     = $clog2(ROB_DEPTH+1);
  localparam int FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FULL_AT  = ROB_DEPTH - ROB_HEADROOM;

  // Reject parameter combinations the counters and flush timer cannot represent.
  if (FLUSH_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_controller: FLUSH_CYCLES and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [FC_W-1:0]   flush_cnt_reg, flush_cnt_next;
  logic [RC_W-1:0]   rob_count_reg, rob_count_next;
  logic [NUM_REGS-1:0] pending;
  logic              enter_flush;
  logic              accept;
  logic              raw_hazard;
  logic              rs1_hit, rs2_hit;

  // State and flush-timer registers; async reset returns to INIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_INIT;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Next-state logic: INIT lasts one clock, redirect (re)starts a flush window.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    enter_flush    = 1'b0;
    case (state_reg)
      ST_INIT: state_next = ST_RUN;
      ST_RUN: begin
        if (redirect) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
          enter_flush    = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
          enter_flush    = 1'b1;
        end else if (flush_cnt_reg == '0) begin
          state_next = ST_RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // RAW detection; a same-cycle writeback to the source forwards and clears it.
  always_comb begin
    rs1_hit    = rs1_used && pending[rs1] && !(wb_valid && (wb_rd == rs1));
    rs2_hit    = rs2_used && pending[rs2] && !(wb_valid && (wb_rd == rs2));
    raw_hazard = rs1_hit || rs2_hit;
  end

  // Stall outputs; RUN is the only state in which anything may advance.
  always_comb begin
    flush          = (state_reg == ST_FLUSH);
    rob_full       = (int'(rob_count_reg) >= FULL_AT);
    backend_stall  = (state_reg == ST_RUN) && backend_busy;
    frontend_stall = (state_reg != ST_RUN) || rob_full || raw_hazard || backend_stall;
    fetch_stall    = (state_reg != ST_RUN) || redirect || icache_busy ||
                     !instr_valid || frontend_stall;
    accept         = dispatch_valid && !frontend_stall;
    rob_count      = rob_count_reg;
  end

  // ROB occupancy update; a flush entry empties the ROB regardless of traffic.
  always_comb begin
    rob_count_next = rob_count_reg;
    if (enter_flush) begin
      rob_count_next = '0;
    end else if (accept && !retire_valid) begin
      rob_count_next = rob_count_reg + 1'b1;
    end else if (retire_valid && !accept && (rob_count_reg != '0)) begin
      rob_count_next = rob_count_reg - 1'b1;
    end
  end

  // ROB occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rob_count_reg <= '0;
    else        rob_count_reg <= rob_count_next;
  end

  // Register 0 is hardwired and can never hold a pending write.
  assign pending[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_sb
      logic set_bit, clr_bit;
      assign set_bit = accept && dispatch_rd_we && (dispatch_rd == RW'(gi));
      assign clr_bit = wb_valid && (wb_rd == RW'(gi));
      // Pending-write bit: flush clears, a new producer wins over writeback.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)           pending[gi] <= 1'b0;
        else if (enter_flush) pending[gi] <= 1'b0;
        else if (set_bit)     pending[gi] <= 1'b1;
        else if (clr_bit)     pending[gi] <= 1'b0;
      end
    end
  endgenerate

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating event counters for fetch stalls in RUN, RAW stalls and flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_stall <= '0;
      perf_raw_stall   <= '0;
      perf_flush       <= '0;
    end else begin
      if ((state_reg == ST_RUN) && fetch_stall && (perf_fetch_stall != CNT_MAX))
        perf_fetch_stall <= perf_fetch_stall + 1'b1;
      if (raw_hazard && (perf_raw_stall != CNT_MAX))
        perf_raw_stall <= perf_raw_stall + 1'b1;
      if (enter_flush && (perf_flush != CNT_MAX))
        perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller (default parameters, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further time unit later, well away from the next edge.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       icache_busy, instr_valid, redirect;
  logic       dispatch_valid, dispatch_rd_we;
  logic [4:0] dispatch_rd, rs1, rs2, wb_rd;
  logic       rs1_used, rs2_used, wb_valid, retire_valid, backend_busy;
  logic       fetch_stall, frontend_stall, backend_stall, flush, rob_full;
  logic [4:0] rob_count;
`ifdef HAZARD_PERF_EN
  logic [3:0] perf_fetch_stall, perf_raw_stall, perf_flush;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .icache_busy(icache_busy), .instr_valid(instr_valid), .redirect(redirect),
    .dispatch_valid(dispatch_valid), .dispatch_rd_we(dispatch_rd_we),
    .dispatch_rd(dispatch_rd),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1(rs1), .rs2(rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .retire_valid(retire_valid),
    .backend_busy(backend_busy),
    .fetch_stall(fetch_stall), .frontend_stall(frontend_stall),
    .backend_stall(backend_stall), .flush(flush), .rob_full(rob_full),
    .rob_count(rob_count)
`ifdef HAZARD_PERF_EN
    ,
    .perf_fetch_stall(perf_fetch_stall), .perf_raw_stall(perf_raw_stall),
    .perf_flush(perf_flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    icache_busy = 1'b0; instr_valid = 1'b1; redirect = 1'b0;
    dispatch_valid = 1'b0; dispatch_rd_we = 1'b0; dispatch_rd = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rs1 = '0; rs2 = '0;
    wb_valid = 1'b0; wb_rd = '0; retire_valid = 1'b0; backend_busy = 1'b0;

    // Reset held for three cycles
    repeat (3) tick();
    #1;
    check("rst_fetch_stall", fetch_stall, 1);
    check("rst_frontend_stall", frontend_stall, 1);
    check("rst_backend_stall", backend_stall, 0);
    check("rst_flush", flush, 0);
    check("rst_rob_full", rob_full, 0);
    check("rst_rob_count", rob_count, 0);

    // Release: one more cycle of INIT, then RUN
    reset = 1'b1;
    #1;
    check("init_fetch_stall", fetch_stall, 1);
    check("init_frontend_stall", frontend_stall, 1);
    tick();
    check("run_fetch_stall", fetch_stall, 0);
    check("run_frontend_stall", frontend_stall, 0);

    // Backend busy and fetch-only stall sources
    backend_busy = 1'b1; #1;
    check("busy_backend_stall", backend_stall, 1);
    check("busy_frontend_stall", frontend_stall, 1);
    backend_busy = 1'b0; icache_busy = 1'b1; #1;
    check("icache_fetch_stall", fetch_stall, 1);
    check("icache_frontend", frontend_stall, 0);
    icache_busy = 1'b0; instr_valid = 1'b0; #1;
    check("novalid_fetch_stall", fetch_stall, 1);
    instr_valid = 1'b1;

    // ROB fill: 15 accepts reach the threshold
    dispatch_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("fill_rob_count", rob_count, 15);
    check("fill_rob_full", rob_full, 1);
    check("fill_frontend_stall", frontend_stall, 1);
    tick();
    check("no_16th_accept", rob_count, 15);
    dispatch_valid = 1'b0; retire_valid = 1'b1;
    tick();
    check("retire_rob_count", rob_count, 14);
    check("retire_rob_full", rob_full, 0);

    // Accept and retire in the same cycle leave the count unchanged
    dispatch_valid = 1'b1;
    tick();
    check("acc_ret_rob_count", rob_count, 14);
    dispatch_valid = 1'b0;
    repeat (4) tick();
    check("drain_rob_count", rob_count, 10);
    retire_valid = 1'b0;

    // Make r9 pending, then redirect
    dispatch_valid = 1'b1; dispatch_rd_we = 1'b1; dispatch_rd = 5'd9;
    tick();
    dispatch_valid = 1'b0; dispatch_rd_we = 1'b0;
    rs1 = 5'd9; rs1_used = 1'b1; #1;
    check("pend9_frontend_stall", frontend_stall, 1);
    check("pend9_rob_count", rob_count, 11);
    rs1_used = 1'b0; redirect = 1'b1; #1;
    check("redirect_fetch_stall", fetch_stall, 1);
    tick();
    redirect = 1'b0; #1;
    check("flush_c1", flush, 1);
    check("flush_rob_count", rob_count, 0);
    check("flush_frontend_stall", frontend_stall, 1);
    tick();
    check("flush_c2", flush, 1);
    tick();
    check("flush_done", flush, 0);
    rs1_used = 1'b1; #1;
    check("sb_cleared_r9", frontend_stall, 0);
    rs1_used = 1'b0;

    // Second redirect in the first flush cycle extends to three cycles
    redirect = 1'b1;
    tick();
    check("ext_c1", flush, 1);
    tick();
    redirect = 1'b0; #1;
    check("ext_c2", flush, 1);
    tick();
    check("ext_c3", flush, 1);
    tick();
    check("ext_done", flush, 0);

    // RAW hazard on r5 until writeback; the writeback cycle bypasses
    dispatch_valid = 1'b1; dispatch_rd_we = 1'b1; dispatch_rd = 5'd5;
    tick();
    dispatch_valid = 1'b0; dispatch_rd_we = 1'b0;
    rs1 = 5'd5; rs1_used = 1'b1; #1;
    check("raw5_frontend", frontend_stall, 1);
    check("raw5_fetch", fetch_stall, 1);
    tick();
    check("raw5_hold", frontend_stall, 1);
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    check("raw5_bypass", frontend_stall, 0);
    tick();
    wb_valid = 1'b0; #1;
    check("raw5_cleared", frontend_stall, 0);
    rs1_used = 1'b0;

    // rd=0 is never pending
    dispatch_valid = 1'b1; dispatch_rd_we = 1'b1; dispatch_rd = 5'd0;
    tick();
    dispatch_valid = 1'b0; rs1 = 5'd0; rs1_used = 1'b1; #1;
    check("r0_no_stall", frontend_stall, 0);
    rs1_used = 1'b0;

    // rs2 path and unused-operand masking on r6
    dispatch_valid = 1'b1; dispatch_rd = 5'd6;
    tick();
    dispatch_valid = 1'b0; dispatch_rd_we = 1'b0;
    rs1 = 5'd6; rs1_used = 1'b0; #1;
    check("r6_unused_no_stall", frontend_stall, 0);
    rs2 = 5'd6; rs2_used = 1'b1; #1;
    check("r6_rs2_stall", frontend_stall, 1);
    wb_valid = 1'b1; wb_rd = 5'd6;
    tick();
    wb_valid = 1'b0; rs2_used = 1'b0;

    // Set and clear of r7 in one cycle: set wins
    dispatch_valid = 1'b1; dispatch_rd_we = 1'b1; dispatch_rd = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    dispatch_valid = 1'b0; dispatch_rd_we = 1'b0; wb_valid = 1'b0;
    rs1 = 5'd7; rs1_used = 1'b1; #1;
    check("r7_set_wins", frontend_stall, 1);
    rs1_used = 1'b0;

    // Asynchronous reset mid-flush drops flush at once
    redirect = 1'b1;
    tick();
    redirect = 1'b0; #1;
    check("pre_abort_flush", flush, 1);
    reset = 1'b0; #1;
    check("abort_flush", flush, 0);
    check("abort_fetch_stall", fetch_stall, 1);
    check("abort_rob_count", rob_count, 0);
    tick();
    reset = 1'b1;
    tick();

`ifdef HAZARD_PERF_EN
    // Saturation of the 4-bit fetch-stall counter
    icache_busy = 1'b1;
    repeat (20) tick();
    check("perf_fetch_sat", perf_fetch_stall, 15);
    check("perf_flush_zero", perf_flush, 0);
    icache_busy = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
